// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown timer.
// Build option: define AUTO_RELOAD_EN for periodic (auto-reload) mode.
package countdown_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_dec.sv
// Combinational decrement: val-1 saturating at zero, plus an is-one flag
// used by the top level to detect terminal count.
module countdown_dec
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_val,
    output logic [WIDTH-1:0] o_dec,
    output logic             o_is_one
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign o_dec    = (i_val == '0) ? '0 : (i_val - ONE);
    assign o_is_one = (i_val == ONE);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/HOLD control and a one-cycle done pulse.
// Define AUTO_RELOAD_EN to reload from the last loaded value at terminal count.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_start,
    input  logic             i_pause,
    output logic [WIDTH-1:0] o_count,
    output logic             o_busy,
    output logic             o_done
);

    // state | meaning
    // IDLE  | stopped; count holds loaded (or terminal) value
    // RUN   | decrementing once per clock
    // HOLD  | paused; count frozen until start without pause

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_busy;
    logic             r_done;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_dec;
    logic             w_is_one;
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
`endif

    countdown_dec #(.WIDTH(WIDTH)) u_dec (
        .i_val    (r_count),
        .o_dec    (w_dec),
        .o_is_one (w_is_one)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
`ifdef AUTO_RELOAD_EN
        w_reload_nxt = r_reload;
`endif
        if (i_load) begin
            w_count_nxt = i_load_val;
            w_state_nxt = IDLE;
`ifdef AUTO_RELOAD_EN
            w_reload_nxt = i_load_val;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start && (r_count != '0))
                        w_state_nxt = RUN;
                end
                RUN: begin
                    if (i_pause) begin
                        w_state_nxt = HOLD;
                    end else if (w_is_one) begin
                        w_done_nxt = 1'b1;
`ifdef AUTO_RELOAD_EN
                        // A zero reload value cannot restart the period.
                        if (r_reload != '0) begin
                            w_count_nxt = r_reload;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = IDLE;
                        end
`else
                        w_count_nxt = '0;
                        w_state_nxt = IDLE;
`endif
                    end else if (r_count == '0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_count_nxt = w_dec;
                    end
                end
                HOLD: begin
                    if (i_start && !i_pause)
                        w_state_nxt = RUN;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_busy  <= (w_state_nxt != IDLE);
            r_done  <= w_done_nxt;
        end
    end

`ifdef AUTO_RELOAD_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_reload <= '0;
        else
            r_reload <= w_reload_nxt;
    end
`endif

    assign o_count = r_count;
    assign o_busy  = r_busy;
    assign o_done  = r_done;

endmodule
